// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: add/sub in one cycle, shift-add multiply and
// restoring-divide remainder over WIDTH cycles, valid/ready on both sides.
module alu_seq #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 sf,
  output logic                 zf,
  output logic                 dzf,
  output logic                 busy
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_REM = 2'b11} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;
  logic             sf_q, sf_d, zf_q, zf_d, dzf_q, dzf_d;

  logic             finish;
  logic [RW-1:0]    fin_result;
  logic             fin_dz;
  logic [WIDTH:0]   rem_shift, rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sf_q     <= 1'b0;
      zf_q     <= 1'b0;
      dzf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sf_q     <= sf_d;
      zf_q     <= zf_d;
      dzf_q    <= dzf_d;
    end
  end

  // mcand_q holds A, shifted left each iteration: it is the multiplicand for
  // mul and supplies dividend bits MSB-first (at bit WIDTH-1) for rem.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    sf_d       = sf_q;
    zf_d       = zf_q;
    dzf_d      = dzf_q;
    finish     = 1'b0;
    fin_result = '0;
    fin_dz     = 1'b0;
    rem_shift  = '0;
    rem_next   = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CALC;
          op_d    = op_t'(op);
          mcand_d = RW'(a);
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      S_CALC: begin
        case (op_q)
          OP_ADD: begin
            finish     = 1'b1;
            fin_result = mcand_q + RW'(b_q);
          end
          OP_SUB: begin
            finish     = 1'b1;
            fin_result = mcand_q - RW'(b_q);
          end
          OP_MUL: begin
            acc_d      = b_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d    = mcand_q << 1;
            b_d        = b_q >> 1;
            fin_result = acc_d;
            cnt_d      = cnt_q + CW'(1);
            finish     = (cnt_q == CW'(WIDTH - 1));
          end
          OP_REM: begin
            if (b_q == '0) begin
              finish = 1'b1;
              fin_dz = 1'b1;
            end else begin
              rem_shift  = {acc_q[WIDTH-1:0], mcand_q[WIDTH-1]};
              rem_next   = (rem_shift >= {1'b0, b_q}) ? (rem_shift - {1'b0, b_q}) : rem_shift;
              acc_d      = RW'(rem_next);
              mcand_d    = mcand_q << 1;
              fin_result = RW'(rem_next[WIDTH-1:0]);
              cnt_d      = cnt_q + CW'(1);
              finish     = (cnt_q == CW'(WIDTH - 1));
            end
          end
          default: ;
        endcase

        if (finish) begin
          state_d  = S_DONE;
          result_d = fin_result;
          dzf_d    = fin_dz;
          zf_d     = (fin_result == '0) & ~fin_dz;
          sf_d     = fin_result[RW-1] & (op_q == OP_SUB) & ~zf_d;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign sf        = sf_q;
  assign zf        = zf_q;
  assign dzf       = dzf_q;

endmodule
